// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle ARMv7 controller, type decoder and datapath.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH  = 4'd0;
  localparam state_t ST_DECODE = 4'd1;
  localparam state_t ST_EXEC   = 4'd2;
  localparam state_t ST_ALUWB  = 4'd3;
  localparam state_t ST_MEMADR = 4'd4;
  localparam state_t ST_MEMRD  = 4'd5;
  localparam state_t ST_MEMWB  = 4'd6;
  localparam state_t ST_MEMWR  = 4'd7;
  localparam state_t ST_BRANCH = 4'd8;
  localparam state_t ST_FAULT  = 4'd9;

  // Instruction class, Instr[27:25]
  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_D = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  // States that own the shared memory port and may wait on MemReady
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory states; flags a timeout when the limit is
// reached and memory is still not ready (MEM_TIMEOUT = 0 disables the flag).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !ready_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = TIMEOUT_EN && en_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARMv7 control FSM: fetch/decode/execute/writeback over a shared,
// variable-latency memory port, with a sticky fault on memory timeout.
module multi_cycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [2:0] Type,
  input  logic       ConditionIsMet,
  input  logic       Load,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       InstrRetired,
  output logic       Fault,
  output logic [3:0] State
);

  state_t state_d, state_q;
  logic   is_imm_d, is_imm_q;
  logic   timeout;
  logic   type_defined;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (CLK),
    .rst_i     (Reset),
    .clr_i     (state_d != state_q),
    .en_i      (is_mem_state(state_q)),
    .ready_i   (MemReady),
    .timeout_o (timeout)
  );

  assign type_defined = (Type == TYPE_R) || (Type == TYPE_I) ||
                        (Type == TYPE_D) || (Type == TYPE_B);

  // Next-state and output decode; IRWrite/PCWrite in FETCH and retire in MEMWR follow MemReady
  always_comb begin
    state_d      = state_q;
    is_imm_d     = is_imm_q;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcB      = SRCB_REG;
    ResultSrc    = RES_ALU;
    InstrRetired = 1'b0;
    Fault        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        is_imm_d = (Type == TYPE_I);
        if (!ConditionIsMet || !type_defined) begin
          InstrRetired = 1'b1;
          state_d      = ST_FETCH;
        end else if (Type == TYPE_D) begin
          state_d = ST_MEMADR;
        end else if (Type == TYPE_B) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUSrcB = is_imm_q ? SRCB_IMM : SRCB_REG;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegWrite     = 1'b1;
        ResultSrc    = RES_ALUOUT;
        InstrRetired = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Load ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (MemReady)     state_d = ST_MEMWB;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_MEMWB: begin
        RegWrite     = 1'b1;
        ResultSrc    = RES_MEM;
        InstrRetired = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) begin
          InstrRetired = 1'b1;
          state_d      = ST_FETCH;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_BRANCH: begin
        ALUSrcB      = SRCB_IMM;
        PCWrite      = 1'b1;
        InstrRetired = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FAULT: begin
        Fault = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Strobes must be quiet the whole time reset is held, not just after the edge
    if (Reset) begin
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcB      = SRCB_REG;
      ResultSrc    = RES_ALU;
      InstrRetired = 1'b0;
      Fault        = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_FETCH;
      is_imm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_imm_q <= is_imm_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle expected output vectors
// are queued by the stimulus and popped/compared by a negedge monitor.
module tb_multi_cycle_controller;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Type = 3'b000;
  logic       ConditionIsMet = 1'b0;
  logic       Load = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       InstrRetired, Fault;
  logic [3:0] State;

  multi_cycle_controller #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .Type(Type), .ConditionIsMet(ConditionIsMet),
    .Load(Load), .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .InstrRetired(InstrRetired),
    .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  // Vector: {State[3:0], MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
  //          ALUSrcB[1:0], ResultSrc[1:0], InstrRetired, Fault}
  localparam logic [15:0] E_RST      = 16'h0000;
  localparam logic [15:0] E_FETCH_W  = 16'h0820;
  localparam logic [15:0] E_FETCH_R  = 16'h09A0;
  localparam logic [15:0] E_DEC      = 16'h1000;
  localparam logic [15:0] E_DEC_RET  = 16'h1002;
  localparam logic [15:0] E_EXEC_R   = 16'h2000;
  localparam logic [15:0] E_EXEC_I   = 16'h2010;
  localparam logic [15:0] E_ALUWB    = 16'h304A;
  localparam logic [15:0] E_MEMADR   = 16'h4010;
  localparam logic [15:0] E_MEMRD    = 16'h5A00;
  localparam logic [15:0] E_MEMWB    = 16'h6046;
  localparam logic [15:0] E_MEMWR_W  = 16'h7600;
  localparam logic [15:0] E_MEMWR_R  = 16'h7602;
  localparam logic [15:0] E_BRANCH   = 16'h8092;
  localparam logic [15:0] E_FAULT    = 16'h9001;

  localparam logic [2:0] T_R = 3'b000, T_I = 3'b001, T_D = 3'b010, T_B = 3'b101, T_U = 3'b011;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e, a;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {State, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcB, ResultSrc, InstrRetired, Fault};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got=%h want=%h", t, $time, a, e);
      end
    end
  end

  // Drive one cycle's inputs, queue its expected outputs, advance to next cycle
  task automatic cyc(input logic rst, input logic [2:0] ty, input logic cond,
                     input logic ld, input logic rdy, input logic [15:0] e,
                     input string t);
    Reset          = rst;
    Type           = ty;
    ConditionIsMet = cond;
    Load           = ld;
    MemReady       = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    cyc(1, T_R, 0, 0, 1, E_RST, "reset0");
    cyc(1, T_R, 0, 0, 1, E_RST, "reset1");

    // R-type, zero wait: CPI 4
    cyc(0, T_R, 1, 0, 1, E_FETCH_R, "r_fetch");
    cyc(0, T_R, 1, 0, 1, E_DEC,     "r_decode");
    cyc(0, T_R, 1, 0, 1, E_EXEC_R,  "r_exec");
    cyc(0, T_R, 1, 0, 1, E_ALUWB,   "r_aluwb");

    // I-type selects the immediate in EXEC
    cyc(0, T_I, 1, 0, 1, E_FETCH_R, "i_fetch");
    cyc(0, T_I, 1, 0, 1, E_DEC,     "i_decode");
    cyc(0, T_R, 1, 0, 1, E_EXEC_I,  "i_exec");
    cyc(0, T_R, 1, 0, 1, E_ALUWB,   "i_aluwb");

    // LDR with 3 wait cycles in MEMRD: 8 cycles total
    cyc(0, T_D, 1, 1, 1, E_FETCH_R, "ldr_fetch");
    cyc(0, T_D, 1, 1, 1, E_DEC,     "ldr_decode");
    cyc(0, T_R, 0, 1, 1, E_MEMADR,  "ldr_memadr");
    for (int i = 0; i < 3; i++) cyc(0, T_R, 0, 0, 0, E_MEMRD, "ldr_memrd_wait");
    cyc(0, T_R, 0, 0, 1, E_MEMRD,   "ldr_memrd_done");
    cyc(0, T_R, 0, 0, 1, E_MEMWB,   "ldr_memwb");

    // Condition-failed branch: 2 cycles
    cyc(0, T_B, 0, 0, 1, E_FETCH_R, "bnc_fetch");
    cyc(0, T_B, 0, 0, 1, E_DEC_RET, "bnc_decode");

    // Taken branch: 3 cycles
    cyc(0, T_B, 1, 0, 1, E_FETCH_R, "b_fetch");
    cyc(0, T_B, 1, 0, 1, E_DEC,     "b_decode");
    cyc(0, T_R, 0, 0, 1, E_BRANCH,  "b_branch");

    // STR zero wait: 4 cycles, retire with MemReady in MEMWR
    cyc(0, T_D, 1, 0, 1, E_FETCH_R, "str_fetch");
    cyc(0, T_D, 1, 0, 1, E_DEC,     "str_decode");
    cyc(0, T_R, 0, 0, 1, E_MEMADR,  "str_memadr");
    cyc(0, T_R, 0, 1, 1, E_MEMWR_R, "str_memwr");

    // Undefined class retires from DECODE
    cyc(0, T_U, 1, 0, 1, E_FETCH_R, "undef_fetch");
    cyc(0, T_U, 1, 0, 1, E_DEC_RET, "undef_decode");

    // MemReady arrives exactly when the counter hits the limit in FETCH
    for (int i = 0; i < 15; i++) cyc(0, T_R, 0, 0, 0, E_FETCH_W, "edge_fetch_wait");
    cyc(0, T_R, 0, 0, 1, E_FETCH_R, "edge_fetch_ready");
    cyc(0, T_R, 0, 0, 1, E_DEC_RET, "edge_decode");

    // Reset mid-MEMRD abandons the load
    cyc(0, T_D, 1, 1, 1, E_FETCH_R, "rst_fetch");
    cyc(0, T_D, 1, 1, 1, E_DEC,     "rst_decode");
    cyc(0, T_R, 0, 1, 1, E_MEMADR,  "rst_memadr");
    cyc(0, T_R, 0, 0, 0, E_MEMRD,   "rst_memrd0");
    cyc(0, T_R, 0, 0, 0, E_MEMRD,   "rst_memrd1");
    cyc(1, T_R, 0, 0, 0, E_RST,     "rst_mid_a");
    cyc(1, T_R, 0, 0, 1, E_RST,     "rst_mid_b");
    cyc(0, T_R, 0, 0, 0, E_FETCH_W, "rst_after_fetch");
    cyc(0, T_R, 0, 0, 1, E_FETCH_R, "rst_after_fetch_rdy");
    cyc(0, T_R, 0, 0, 1, E_DEC_RET, "rst_after_decode");

    // STR with memory never ready: 16 cycles in MEMWR then sticky FAULT
    cyc(0, T_D, 1, 0, 1, E_FETCH_R, "to_fetch");
    cyc(0, T_D, 1, 0, 1, E_DEC,     "to_decode");
    cyc(0, T_R, 0, 0, 1, E_MEMADR,  "to_memadr");
    for (int i = 0; i < 16; i++) cyc(0, T_R, 0, 0, 0, E_MEMWR_W, "to_memwr_wait");
    cyc(0, T_R, 0, 0, 0, E_FAULT,   "to_fault0");
    cyc(0, T_R, 1, 1, 1, E_FAULT,   "to_fault_rdy");
    cyc(0, T_B, 1, 0, 0, E_FAULT,   "to_fault2");
    cyc(1, T_R, 0, 0, 0, E_RST,     "to_reset");
    cyc(0, T_R, 0, 0, 0, E_FETCH_W, "to_recover");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle control FSM that sequences the ARMv7 datapath over several clocks per instruction, so instruction and data memory can share one port with variable latency. Each instruction goes fetch → decode → execute/memory → writeback; the FSM drives the register-enable, mux-select and memory strobes. It is dispatched from the class encoding (I/R/D/B) and the condition check. A memory-wait timer forces a sticky fault when memory never responds.

## Interface

Parameters:
- MEM_TIMEOUT, 15, maximum cycles a memory state waits with MemReady low before faulting; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Type  in  3  instruction class, Instr[27:25]: 000 R, 001 I, 010 D, 101 B, others undefined.
- ConditionIsMet  in  1  condition-check result for the instruction in IR; valid in DECODE.
- Load  in  1  Instr[20]; for D class, 1 = LDR, 0 = STR.
- MemReady  in  1  memory completes the current access this cycle.
- MemRead  out  1  read request.
- MemWrite  out  1  write request.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC from the Result bus.
- RegWrite  out  1  register-file write enable.
- ALUSrcB  out  2  00 = register, 01 = extended immediate, 10 = constant 4.
- ResultSrc  out  2  00 = ALU (direct), 01 = memory data, 10 = ALUOut.
- InstrRetired  out  1  one-cycle pulse when an instruction completes.
- Fault  out  1  sticky memory-timeout indication.
- State  out  4  current state encoding, for debug.

## Operation

States and their outputs. Any output not listed is 0.
- FETCH
  - Drives MemRead=1, AdrSrc=0, ALUSrcB=10, ResultSrc=00.
  - On MemReady: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE
  - Drives no strobes. Dispatches on the class:
  - ConditionIsMet=0, or an undefined Type: InstrRetired=1, go to FETCH.
  - R or I: go to EXEC.
  - D: go to MEMADR.
  - B: go to BRANCH.
- EXEC
  - ALUSrcB = 00 for R, 01 for I. The class is latched into a 1-bit register in DECODE.
  - Go to ALUWB.
- ALUWB
  - RegWrite=1, ResultSrc=10, InstrRetired=1. Go to FETCH.
- MEMADR
  - ALUSrcB=01.
  - Load=1: go to MEMRD. Load=0: go to MEMWR.
- MEMRD
  - MemRead=1, AdrSrc=1.
  - On MemReady: go to MEMWB. Otherwise stay.
- MEMWB
  - RegWrite=1, ResultSrc=01, InstrRetired=1. Go to FETCH.
- MEMWR
  - MemWrite=1, AdrSrc=1.
  - On MemReady: InstrRetired=1, go to FETCH.
- BRANCH
  - ALUSrcB=01, ResultSrc=00, PCWrite=1, InstrRetired=1. Go to FETCH.
- FAULT
  - All strobes 0, Fault=1. Leaves only on Reset.

Memory-wait timer:
- Applies only in FETCH, MEMRD and MEMWR.
- Cleared on entry to any state.
- Increments each cycle that MemReady is low, saturating at MEM_TIMEOUT.
- If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT while MemReady is still low: go to FAULT on the next edge. A MemReady arriving that same cycle wins.
- Counter width: $clog2(MEM_TIMEOUT+1), minimum 1.

Load is sampled in MEMADR. ConditionIsMet and Type are sampled in DECODE only.

## Timing

- Reset asserted:
  - State = FETCH (encoding 0), timer 0, Fault 0.
  - All strobes and InstrRetired are forced to 0 combinationally while Reset is high.
  - Reset mid-access abandons the access with no retire pulse.
- Outputs are decoded from state (Moore). Exceptions (Mealy on MemReady): IRWrite/PCWrite in FETCH, and InstrRetired in MEMWR.
- Cycles per instruction with zero wait (MemReady held high):
  - Condition-failed: 2.
  - B: 3.
  - R, I, STR: 4.
  - LDR: 5.
- Each memory wait cycle adds one cycle.
- Maximum stall before a fault: MEM_TIMEOUT+1 cycles in one memory state.
- MemRead and MemWrite are never high together. InstrRetired is high for at most one cycle per instruction.

## Structure

- Shared package ctrl_pkg:
  - State enum, 4 bits, FETCH=0.
  - Type class encodings.
  - ALUSrcB and ResultSrc select constants.
  - These are shared with the type decoder and the datapath.
- One sub-module, mem_wait_timer: clear, count enable, ready input and timeout output, parameterized by MEM_TIMEOUT.
- The FSM next-state logic and output decode stay in multi_cycle_controller.

## Test plan

- R-type, cond met, MemReady=1 → states FETCH, DECODE, EXEC, ALUWB. RegWrite high in cycle 4 only; InstrRetired pulses in cycle 4; CPI 4.
- LDR with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with ResultSrc=01; total 8 cycles; no fault.
- Condition-failed B (ConditionIsMet=0) → FETCH, DECODE, FETCH. PCWrite only in FETCH; InstrRetired in DECODE; no RegWrite or MemWrite.
- STR, MEM_TIMEOUT=15, MemReady never asserted in MEMWR → FAULT after 16 cycles in MEMWR; Fault stays 1, strobes 0, until Reset.
- MemReady rising in the same cycle the counter reaches MEM_TIMEOUT in FETCH → DECODE, not FAULT.
- Reset pulsed mid-MEMRD → State=0 and MemRead=0 during Reset; after release, FETCH with MemRead=1 and no retire pulse.
